change_dispenser: RTL
=====================

// Module: change_dispenser
// PURPOSE
//  Back end of the vending FSM. Consumes its one-cycle release strobe (p) and change codes
//  (c1, c2 in cents: 0/5/10). Drives the can-release motor, then ejects change one coin at a time.
//  Each coin uses a solenoid pulse and waits for a sensor ack. Tracks nickel/dime inventory and
//  flags exact-change-only and jam conditions. Sits between vending_fsm and the mechanism I/O.
// PARAMETERS
//  PULSE_CYC    4    cycles each eject solenoid is held high
//  ACK_TIMEOUT  64   cycles to wait for vend_done/coin_seen before declaring jam
//  NICKEL_INIT  20   nickel inventory after reset
//  DIME_INIT    20   dime inventory after reset
// PORTS
//  clock         in   1  system clock
//  reset         in   1  synchronous, active-high
//  p             in   1  release strobe from vending FSM, 1-cycle pulse
//  c1, c2        in   4  change amounts in cents, valid with p (legal: 0,5,10)
//  vend_done     in   1  can-chute sensor pulse
//  coin_seen     in   1  coin-exit sensor pulse, one per ejected coin
//  refill_nickel in   1  pulse: +1 nickel to inventory
//  refill_dime   in   1  pulse: +1 dime to inventory
//  vend_motor    out  1  can-release motor enable
//  eject_nickel  out  1  nickel solenoid
//  eject_dime    out  1  dime solenoid
//  busy          out  1  request active or pending; upstream gates coin acceptance
//  exact_change  out  1  inventory cannot guarantee 20c change
//  short_change  out  1  sticky: a request was under-paid for lack of coins
//  err_overflow  out  1  sticky: request dropped (active + pending both occupied)
//  err_code      out  1  sticky: illegal c1/c2 value seen
//  jam           out  1  sticky: ack timeout; FSM halted until reset
//  nickel_cnt    out  8  current nickel inventory
//  dime_cnt      out  8  current dime inventory
// BEHAVIOUR
//  Reset: all outputs 0 except nickel_cnt=NICKEL_INIT and dime_cnt=DIME_INIT; exact_change recomputed.
//   Pending buffer is emptied. Reset mid-operation aborts everything on the next edge.
//  Capture: on p, total = c1' + c2', where an illegal code maps to 0 and sets err_code (5-bit sum, 0..20).
//   The request goes to active if FSM is IDLE, else to the 1-entry pending buffer.
//   If both are full, the request is dropped and err_overflow is set.
//  States: IDLE -> VEND -> SELECT -> EJECT -> WAIT_ACK -> SELECT ... -> IDLE; any state -> JAM.
//   IDLE: take pending if valid, else a new p. vend_motor rises the cycle after p (1-cycle latency).
//   VEND: vend_motor=1 until vend_done, then SELECT. After ACK_TIMEOUT cycles with no vend_done -> JAM.
//   SELECT: rem>=10 and dime_cnt>0 -> dime.
//           else rem>=5 and nickel_cnt>0 -> nickel (a dime is paid as two nickels).
//           else rem>0 -> set short_change, go to IDLE.
//           else rem==0 -> IDLE.
//   EJECT: the selected solenoid is high exactly PULSE_CYC cycles; the other solenoid stays 0.
//   WAIT_ACK: on coin_seen, rem -= coin value and the matching count decrements; then SELECT.
//     After ACK_TIMEOUT cycles with no coin_seen -> JAM. coin_seen outside WAIT_ACK is ignored.
//   JAM: all actuators 0, jam=1, busy=1; leaves only on reset.
//  Inventory: 8-bit counters. Refill saturates at 255. Refill and dispense in the same cycle: net 0.
//  exact_change is registered: 1 when 5*nickel_cnt + 10*dime_cnt < 20, or when nickel_cnt==0.
//  busy = (state!=IDLE) | pending_valid.
// STRUCTURE
//  vend_pkg: coin values (5,10), state encoding, code-legality function, change-width constant.
//  Sub-module coin_pulse_timer: loadable down-counter for the PULSE_CYC pulse and the ACK_TIMEOUT
//   watchdog; outputs pulse_active and timeout.
// TESTING
//  1. p with c1=10,c2=5; vend_done after 3 cycles; ack each coin.
//     -> vend_motor 1 for 3 cycles; dime pulse 4 cycles, then nickel pulse;
//        dime_cnt=19, nickel_cnt=19; busy drops.
//  2. dime_cnt forced to 0 via reset param DIME_INIT=0; request c1=10,c2=10.
//     -> four nickel ejects, nickel_cnt=16, exact_change=0.
//  3. NICKEL_INIT=1, DIME_INIT=0; request 10c.
//     -> one nickel ejected, short_change=1, nickel_cnt=0, exact_change=1.
//  4. Three p strobes 2 cycles apart while first vend active.
//     -> 2nd held pending and serviced after first; 3rd dropped, err_overflow=1.
//  5. Withhold coin_seen.
//     -> jam=1 after ACK_TIMEOUT cycles, solenoids 0.
//     reset mid-VEND -> all outputs cleared next cycle.
//  6. c1=4'd7 with p -> err_code=1, treated as 0, only can released.
//     refill_dime with coin_seen(dime) same cycle -> dime_cnt unchanged.

Source files
------------

// File: rtl/vend_pkg.sv
// Shared types and helpers for the vending back end: coin values, FSM
// encoding, change-code legality and the inventory exact-change test.
package vend_pkg;

    localparam int CHG_W = 5;
    localparam int TMR_W = 8;

    localparam logic [CHG_W-1:0] NICKEL_VAL = 5'd5;
    localparam logic [CHG_W-1:0] DIME_VAL   = 5'd10;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_VEND     = 3'd1,
        ST_SELECT   = 3'd2,
        ST_EJECT    = 3'd3,
        ST_WAIT_ACK = 3'd4,
        ST_JAM      = 3'd5
    } state_e;

    function automatic logic code_legal(input logic [3:0] code);
        return (code == 4'd0) || (code == 4'd5) || (code == 4'd10);
    endfunction

    function automatic logic [CHG_W-1:0] code_value(input logic [3:0] code);
        logic [CHG_W-1:0] val;
        if (code_legal(code)) begin
            val = {1'b0, code};
        end else begin
            val = 5'd0;
        end
        return val;
    endfunction

    // Too little money in the tubes for 20c, or no nickels to make odd change.
    function automatic logic exact_change_f(input logic [7:0] nickels, input logic [7:0] dimes);
        logic [10:0] total;
        total = ({3'd0, nickels} * 11'd5) + ({3'd0, dimes} * 11'd10);
        return (total < 11'd20) || (nickels == 8'd0);
    endfunction

endpackage

// File: rtl/coin_pulse_timer.sv
// Loadable down-counter shared by the solenoid pulse width and the
// acknowledge watchdog; idles at zero once expired.
module coin_pulse_timer
    import vend_pkg::*;
(
    input  logic             clock,
    input  logic             reset,
    input  logic             load_i,
    input  logic [TMR_W-1:0] load_val_i,
    output logic             pulse_active_o,
    output logic             timeout_o
);

    logic [TMR_W-1:0] cnt_q;

    // Down-counter register, reload has priority over counting.
    always_ff @(posedge clock) begin
        if (reset) begin
            cnt_q <= '0;
        end else if (load_i) begin
            cnt_q <= load_val_i;
        end else if (cnt_q != '0) begin
            cnt_q <= cnt_q - 8'd1;
        end else begin
            cnt_q <= cnt_q;
        end
    end

    assign pulse_active_o = (cnt_q != '0);
    assign timeout_o      = (cnt_q == '0);

endmodule

// File: rtl/change_dispenser.sv
// Releases the can, then pays change one coin at a time with solenoid
// pulses and sensor acks, tracking inventory and sticky error flags.
module change_dispenser
    import vend_pkg::*;
#(
    parameter int PULSE_CYC   = 4,
    parameter int ACK_TIMEOUT = 64,
    parameter int NICKEL_INIT = 20,
    parameter int DIME_INIT   = 20
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       p,
    input  logic [3:0] c1,
    input  logic [3:0] c2,
    input  logic       vend_done,
    input  logic       coin_seen,
    input  logic       refill_nickel,
    input  logic       refill_dime,
    output logic       vend_motor,
    output logic       eject_nickel,
    output logic       eject_dime,
    output logic       busy,
    output logic       exact_change,
    output logic       short_change,
    output logic       err_overflow,
    output logic       err_code,
    output logic       jam,
    output logic [7:0] nickel_cnt,
    output logic [7:0] dime_cnt
);

    localparam logic [TMR_W-1:0] PULSE_LD = TMR_W'(PULSE_CYC - 1);
    localparam logic [TMR_W-1:0] ACK_LD   = TMR_W'(ACK_TIMEOUT - 1);

    state_e           state_q, state_d;
    logic [CHG_W-1:0] rem_q, rem_d, pend_amt_q, pend_amt_d, req_amt_s;
    logic             is_dime_q, is_dime_d, pend_valid_q, pend_valid_d;
    logic [7:0]       nickel_q, nickel_d, dime_q, dime_d;
    logic             short_q, short_d, ovf_q, ovf_d, code_q, code_d;
    logic             vend_motor_q, eject_nickel_q, eject_dime_q, busy_q, jam_q, exact_q;
    logic             tmr_load_s, tmr_active_s, tmr_timeout_s, idle_direct_s;
    logic             disp_n_s, disp_d_s;
    logic [TMR_W-1:0] tmr_val_s;

    coin_pulse_timer u_timer (
        .clock          (clock),
        .reset          (reset),
        .load_i         (tmr_load_s),
        .load_val_i     (tmr_val_s),
        .pulse_active_o (tmr_active_s),
        .timeout_o      (tmr_timeout_s)
    );

    // Request capture, coin FSM next state and inventory update.
    always_comb begin
        state_d       = state_q;
        rem_d         = rem_q;
        is_dime_d     = is_dime_q;
        pend_valid_d  = pend_valid_q;
        pend_amt_d    = pend_amt_q;
        short_d       = short_q;
        ovf_d         = ovf_q;
        code_d        = code_q;
        tmr_load_s    = 1'b0;
        tmr_val_s     = ACK_LD;
        disp_n_s      = 1'b0;
        disp_d_s      = 1'b0;
        req_amt_s     = code_value(c1) + code_value(c2);
        idle_direct_s = (state_q == ST_IDLE) && !pend_valid_q;

        if (p && (!code_legal(c1) || !code_legal(c2))) begin
            code_d = 1'b1;
        end else begin
            code_d = code_q;
        end

        // In IDLE the pending slot empties this cycle, so a new strobe may refill it.
        if (p && !idle_direct_s) begin
            if (!pend_valid_q || (state_q == ST_IDLE)) begin
                pend_valid_d = 1'b1;
                pend_amt_d   = req_amt_s;
            end else begin
                ovf_d = 1'b1;
            end
        end else if ((state_q == ST_IDLE) && pend_valid_q) begin
            pend_valid_d = 1'b0;
        end else begin
            pend_valid_d = pend_valid_q;
        end

        case (state_q)
            ST_IDLE: begin
                if (pend_valid_q) begin
                    state_d    = ST_VEND;
                    rem_d      = pend_amt_q;
                    tmr_load_s = 1'b1;
                end else if (p) begin
                    state_d    = ST_VEND;
                    rem_d      = req_amt_s;
                    tmr_load_s = 1'b1;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_VEND: begin
                if (vend_done) begin
                    state_d = ST_SELECT;
                end else if (tmr_timeout_s) begin
                    state_d = ST_JAM;
                end else begin
                    state_d = ST_VEND;
                end
            end
            ST_SELECT: begin
                if ((rem_q >= DIME_VAL) && (dime_q != 8'd0)) begin
                    is_dime_d  = 1'b1;
                    state_d    = ST_EJECT;
                    tmr_load_s = 1'b1;
                    tmr_val_s  = PULSE_LD;
                end else if ((rem_q >= NICKEL_VAL) && (nickel_q != 8'd0)) begin
                    is_dime_d  = 1'b0;
                    state_d    = ST_EJECT;
                    tmr_load_s = 1'b1;
                    tmr_val_s  = PULSE_LD;
                end else if (rem_q != 5'd0) begin
                    short_d = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_EJECT: begin
                if (tmr_active_s) begin
                    state_d = ST_EJECT;
                end else begin
                    state_d    = ST_WAIT_ACK;
                    tmr_load_s = 1'b1;
                end
            end
            ST_WAIT_ACK: begin
                if (coin_seen) begin
                    rem_d    = rem_q - (is_dime_q ? DIME_VAL : NICKEL_VAL);
                    disp_d_s = is_dime_q;
                    disp_n_s = !is_dime_q;
                    state_d  = ST_SELECT;
                end else if (tmr_timeout_s) begin
                    state_d = ST_JAM;
                end else begin
                    state_d = ST_WAIT_ACK;
                end
            end
            ST_JAM: begin
                state_d = ST_JAM;
            end
            default: begin
                state_d = ST_JAM;
            end
        endcase

        if (refill_nickel && !disp_n_s) begin
            nickel_d = (nickel_q == 8'd255) ? nickel_q : nickel_q + 8'd1;
        end else if (!refill_nickel && disp_n_s) begin
            nickel_d = nickel_q - 8'd1;
        end else begin
            nickel_d = nickel_q;
        end

        if (refill_dime && !disp_d_s) begin
            dime_d = (dime_q == 8'd255) ? dime_q : dime_q + 8'd1;
        end else if (!refill_dime && disp_d_s) begin
            dime_d = dime_q - 8'd1;
        end else begin
            dime_d = dime_q;
        end
    end

    // State, inventory and output registers; outputs decode the next state.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q        <= ST_IDLE;
            rem_q          <= 5'd0;
            is_dime_q      <= 1'b0;
            pend_valid_q   <= 1'b0;
            pend_amt_q     <= 5'd0;
            nickel_q       <= 8'(NICKEL_INIT);
            dime_q         <= 8'(DIME_INIT);
            short_q        <= 1'b0;
            ovf_q          <= 1'b0;
            code_q         <= 1'b0;
            vend_motor_q   <= 1'b0;
            eject_nickel_q <= 1'b0;
            eject_dime_q   <= 1'b0;
            busy_q         <= 1'b0;
            jam_q          <= 1'b0;
            exact_q        <= exact_change_f(8'(NICKEL_INIT), 8'(DIME_INIT));
        end else begin
            state_q        <= state_d;
            rem_q          <= rem_d;
            is_dime_q      <= is_dime_d;
            pend_valid_q   <= pend_valid_d;
            pend_amt_q     <= pend_amt_d;
            nickel_q       <= nickel_d;
            dime_q         <= dime_d;
            short_q        <= short_d;
            ovf_q          <= ovf_d;
            code_q         <= code_d;
            vend_motor_q   <= (state_d == ST_VEND);
            eject_nickel_q <= (state_d == ST_EJECT) && !is_dime_d;
            eject_dime_q   <= (state_d == ST_EJECT) && is_dime_d;
            busy_q         <= (state_d != ST_IDLE) || pend_valid_d;
            jam_q          <= (state_d == ST_JAM);
            exact_q        <= exact_change_f(nickel_d, dime_d);
        end
    end

    assign vend_motor   = vend_motor_q;
    assign eject_nickel = eject_nickel_q;
    assign eject_dime   = eject_dime_q;
    assign busy         = busy_q;
    assign exact_change = exact_q;
    assign short_change = short_q;
    assign err_overflow = ovf_q;
    assign err_code     = code_q;
    assign jam          = jam_q;
    assign nickel_cnt   = nickel_q;
    assign dime_cnt     = dime_q;

endmodule
